// File: rtl/pow2_approx.sv
// pow2_approx: two-stage pipelined approximation of 2^x for a signed Q4.12
// exponent. The integer part of x selects a shift and the fraction supplies
// the Q1.12 mantissa 1.f (Mitchell-style linear interpolation between
// powers of two). Results with an integer part of 3 or more clip to 16'h7FFF.
module pow2_approx #(
  parameter int W    = 16,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ready,
  input  logic [W-1:0] in_x,
  output logic [W-1:0] pow2_x,
  output logic         valid,
  output logic [W-1:0] out_x,
  output logic         sat
);

  // Width of the integer part of the exponent (4 for Q4.12).
  localparam int IW = W - FRAC;
  // Smallest non-negative integer part whose result no longer fits below
  // the signed maximum of the output word.
  localparam logic [IW-2:0] SAT_I = (IW-1)'(IW - 1);
  localparam logic [W-1:0]  SAT_VALUE = {1'b0, {(W-1){1'b1}}};

  // Stage-1 registers.
  logic [W-1:0] x_reg;
  logic         v1_reg;

  // Stage-2 registers.
  logic [W-1:0] pow2_x_reg;
  logic [W-1:0] out_x_reg;
  logic         sat_reg;
  logic         valid_reg;

  // Stage-2 next values, derived from stage-1 registers only.
  logic signed [IW-1:0] int_part;
  logic [IW-1:0]        neg_amt;
  logic [W-1:0]         mant_ext;
  logic [W-1:0]         shifted;
  logic                 sat_next;
  logic [W-1:0]         pow2_next;

  // The top IW bits of x are exactly floor(x) as a signed integer, which is
  // what an arithmetic right shift by FRAC would produce.
  assign int_part = x_reg[W-1:FRAC];
  // Magnitude of a negative integer part; -8 maps to 4'b1000 = 8 as needed.
  assign neg_amt  = IW'(-int_part);
  // Mantissa 1.f in Q1.12. Non-saturating left shifts are at most 2, so the
  // result (<= 32764) always fits in W bits; larger shifts are clipped anyway.
  assign mant_ext = W'({1'b1, x_reg[FRAC-1:0]});

  // Shift the mantissa by the integer part and apply the saturation rule.
  always_comb begin
    shifted   = '0;
    sat_next  = 1'b0;
    pow2_next = '0;
    if (int_part[IW-1]) begin
      shifted = mant_ext >> neg_amt;
    end else begin
      shifted = mant_ext << int_part[IW-2:0];
    end
    sat_next  = ~int_part[IW-1] & (int_part[IW-2:0] >= SAT_I);
    pow2_next = sat_next ? SAT_VALUE : shifted;
  end

  // Both pipeline stages advance together on enabled edges; reset clears all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg      <= '0;
      v1_reg     <= 1'b0;
      pow2_x_reg <= '0;
      out_x_reg  <= '0;
      sat_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else if (en) begin
      x_reg      <= in_x;
      v1_reg     <= ready;
      pow2_x_reg <= pow2_next;
      out_x_reg  <= x_reg;
      sat_reg    <= sat_next;
      valid_reg  <= v1_reg;
    end
  end

  assign pow2_x = pow2_x_reg;
  assign out_x  = out_x_reg;
  assign sat    = sat_reg;
  assign valid  = valid_reg;

endmodule

// File: tb/tb_pow2_approx.sv
// tb_pow2_approx: randomized and directed stimulus for pow2_approx, checked
// every cycle against a plain-arithmetic model of 2^x and a two-enabled-edge
// latency history, plus literal expectations for the directed cases.
module tb_pow2_approx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] in_x = 16'h0000;
  logic [15:0] pow2_x;
  logic        valid;
  logic [15:0] out_x;
  logic        sat;

  int n_checks = 0;
  int n_fail   = 0;

  pow2_approx #(.W(16), .FRAC(12)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ready  (ready),
    .in_x   (in_x),
    .pow2_x (pow2_x),
    .valid  (valid),
    .out_x  (out_x),
    .sat    (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference 2^x: floor split of x into integer and fraction, then
  // (1 + f) * 2^I in Q4.12 with truncating division for negative I.
  function automatic logic [16:0] model(input logic [15:0] x);
    int xi;
    int f;
    int i;
    int r;
    xi = int'($signed(x));
    f  = xi & 4095;
    i  = (xi - f) / 4096;
    if (i >= 3) return {1'b1, 16'h7FFF};
    if (i >= 0) r = (4096 + f) * (1 << i);
    else        r = (4096 + f) / (1 << (-i));
    return {1'b0, r[15:0]};
  endfunction

  typedef struct packed {
    logic        rdy;
    logic [15:0] x;
  } samp_t;

  // Samples seen at the last two enabled edges; the older one is what the
  // outputs must show now.
  samp_t hist[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
    end else if (en) begin
      hist.push_back({ready, in_x});
      if (hist.size() > 2) void'(hist.pop_front());
    end
  end

  // Per-cycle comparison, sampled well after the active edge.
  always begin
    logic [16:0] exp_r;
    @(posedge clk);
    #4;
    if (!rst) begin
      chk("cmp_rst_valid", 32'(valid), 32'd0);
      chk("cmp_rst_pow2", 32'(pow2_x), 32'd0);
    end else if (hist.size() >= 2 && hist[0].rdy) begin
      exp_r = model(hist[0].x);
      chk("cmp_valid", 32'(valid), 32'd1);
      chk("cmp_pow2", 32'(pow2_x), 32'(exp_r[15:0]));
      chk("cmp_sat", 32'(sat), 32'(exp_r[16]));
      chk("cmp_out_x", 32'(out_x), 32'(hist[0].x));
    end else begin
      chk("cmp_valid_low", 32'(valid), 32'd0);
    end
  end

  // One strobe, then a literal check of the result two edges later.
  task automatic directed(input logic [15:0] x, input logic [15:0] exp_p, input logic exp_s);
    ready = 1'b1;
    in_x  = x;
    @(negedge clk);
    ready = 1'b0;
    in_x  = 16'($urandom);
    @(negedge clk);
    chk("dir_valid", 32'(valid), 32'd1);
    chk("dir_pow2", 32'(pow2_x), 32'(exp_p));
    chk("dir_sat", 32'(sat), 32'(exp_s));
    chk("dir_out_x", 32'(out_x), 32'(x));
    $display("directed in_x=%h pow2_x=%h sat=%0d", x, pow2_x, sat);
  endtask

  initial begin
    logic        pv;
    logic [15:0] pp;
    logic [16:0] m;

    // Hand-computed values pinning the model itself.
    m = model(16'hF100); chk("model_f100", 32'(m), 32'h00880);
    m = model(16'h2FFF); chk("model_2fff", 32'(m), 32'h07FFC);
    m = model(16'hFFFF); chk("model_ffff", 32'(m), 32'h00FFF);
    m = model(16'h3000); chk("model_3000", 32'(m), 32'h17FFF);
    for (int k = -8; k <= 2; k++) begin
      m = model(16'(k * 4096));
      chk("model_pow2_exact", 32'(m), 32'(1 << (k + 12)));
    end

    // Reset, with en/ready active to show they have no effect.
    #1 rst = 1'b0;
    en = 1'b1;
    ready = 1'b1;
    in_x = 16'h1000;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_pow2", 32'(pow2_x), 32'd0);
    chk("reset_out_x", 32'(out_x), 32'd0);
    chk("reset_sat", 32'(sat), 32'd0);
    rst = 1'b1;
    ready = 1'b0;
    @(negedge clk);

    // Directed values and saturation.
    directed(16'h0000, 16'h1000, 1'b0);
    directed(16'hF000, 16'h0800, 1'b0);
    directed(16'hF800, 16'h0C00, 1'b0);
    directed(16'h1800, 16'h3000, 1'b0);
    directed(16'h8000, 16'h0010, 1'b0);
    directed(16'h2FFF, 16'h7FFC, 1'b0);
    directed(16'h3000, 16'h7FFF, 1'b1);
    directed(16'h7FFF, 16'h7FFF, 1'b1);

    // Streaming ramp F000..F700: results in order from the second edge on.
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        chk("stream_valid", 32'(valid), 32'd1);
        chk("stream_out_x", 32'(out_x), 32'(16'hF000 + 16'((i - 2) * 256)));
      end
      if (i < 8) begin
        ready = 1'b1;
        in_x  = 16'hF000 + 16'(i * 256);
      end else begin
        ready = 1'b0;
      end
      @(negedge clk);
    end
    $display("stream ramp done");

    // Stall: strobe 1.0, freeze for 3 cycles after the first edge.
    ready = 1'b1;
    in_x  = 16'h1000;
    @(negedge clk);
    en = 1'b0;
    pv = valid;
    pp = pow2_x;
    for (int i = 0; i < 3; i++) begin
      in_x = 16'($urandom);
      @(negedge clk);
      chk("stall_valid_hold", 32'(valid), 32'(pv));
      chk("stall_pow2_hold", 32'(pow2_x), 32'(pp));
    end
    en = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    chk("stall_valid", 32'(valid), 32'd1);
    chk("stall_pow2", 32'(pow2_x), 32'h2000);
    $display("stall pow2_x=%h valid=%0d", pow2_x, valid);

    // Reset in the middle of a stream.
    for (int i = 0; i < 4; i++) begin
      ready = 1'b1;
      in_x  = 16'h0400 + 16'(i * 512);
      @(negedge clk);
    end
    chk("midrst_pre_valid", 32'(valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_pow2", 32'(pow2_x), 32'd0);
    @(negedge clk);
    in_x = 16'h1234;
    @(negedge clk);
    rst = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(valid), 32'd0);
    end
    $display("reset mid-stream done");

    // Randomized traffic with enable gaps, bubbles and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en    = ($urandom_range(0, 9) < 8);
      ready = ($urandom_range(0, 9) < 7);
      in_x  = 16'($urandom);
      rst   = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    $display("random phase done");

    // Exhaustive sweep of every exponent, streamed back to back.
    for (int i = 0; i < 65536; i++) begin
      ready = 1'b1;
      in_x  = 16'(i);
      @(negedge clk);
    end
    ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("sweep done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pow2_approx.md
POW2_APPROX -- requirements
Module: pow2_approx

Interface
REQ-001 SHALL have parameter W, default 16: data word width in bits.
REQ-002 SHALL have parameter FRAC, default 12: fractional bits (Q4.12); all arithmetic below is stated for the defaults.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 en  input  1  pipeline enable; 0 = every register holds.
REQ-006 ready  input  1  input strobe; in_x is valid in the cycle ready=1.
REQ-007 in_x  input  W  signed Q4.12 exponent x.
REQ-008 pow2_x  output  W  unsigned Q4.12 result approximating 2^x.
REQ-009 valid  output  1  pow2_x/out_x/sat valid.
REQ-010 out_x  output  W  in_x echoed, aligned with pow2_x.
REQ-011 sat  output  1  result was clipped to 16'h7FFF.

Function
REQ-012 SHALL be a 2-stage pipeline; stage registers load only on rising edges with en=1.
REQ-013 Stage 1 (edge with en=1): capture x=in_x, v1=ready; I = x>>>12 (arithmetic, range -8..7); f = x[11:0].
REQ-014 Stage 2 (same edge, from stage-1 regs): m = 4096+f (13-bit, Q1.12, [1,2)); I>=0: r = m<<I; I<0: r = m>>(-I), truncating.
REQ-015 I>=3 SHALL give pow2_x=16'h7FFF, sat=1; otherwise pow2_x=r[15:0], sat=0 (r <= 32764 guaranteed).
REQ-016 Stage 2 SHALL register pow2_x, sat, out_x=x and valid=v1.
REQ-017 Latency: ready=1 sampled at edge N (en=1 at N and N+1) -> valid=1 with result after edge N+1.
REQ-018 Throughput: one sample per enabled cycle; ready held high gives valid high every cycle after 2-cycle fill.
REQ-019 ready=0 at an enabled edge SHALL propagate a bubble (valid=0 two enabled edges later); data regs may load but are don't-care when valid=0.
REQ-020 en=0 SHALL freeze both stages, outputs and valid unchanged; ready/in_x ignored during freeze.
REQ-021 valid SHALL be a level: stays 1 across en=0 cycles until the next enabled edge.
REQ-022 No state machine beyond v1/valid pipeline flags; no combinational path in_x -> outputs.
REQ-023 Result is the Mitchell-style inverse of the team's log2 approximation: pow2(log2_approx(x)) SHALL return x exactly for x = 2^k, k in -8..2.

Reset
REQ-024 rst=0 SHALL asynchronously clear all registers: pow2_x=0, out_x=0, sat=0, valid=0, v1=0.
REQ-025 Reset mid-operation SHALL discard in-flight samples; first valid after rst release requires a fresh ready plus 2 enabled edges.
REQ-026 en and ready SHALL have no effect while rst=0.

Verification
REQ-027 Directed values, en=1, one strobe each: in_x 16'h0000 -> pow2_x 16'h1000; 16'hF000 (-1.0) -> 16'h0800; 16'hF800 (-0.5) -> 16'h0C00; 16'h1800 (1.5) -> 16'h3000; 16'h8000 (-8.0) -> 16'h0010; all sat=0, out_x=in_x.
REQ-028 Saturation: in_x 16'h3000 and 16'h7FFF -> pow2_x 16'h7FFF, sat=1, valid=1 after 2 edges.
REQ-029 Streaming: ready=1 for 8 consecutive cycles, in_x ramping 16'hF000..16'hF700 -> 8 consecutive valid results in order, first after edge 2, out_x matching.
REQ-030 Stall: strobe 16'h1000, drop en for 3 cycles after edge 1 -> outputs/valid frozen; on re-enable pow2_x=16'h2000 after one further edge.
REQ-031 Reset mid-stream: assert rst=0 between two strobes -> valid=0 and pow2_x=0 immediately (asynchronous), no stale result after release.
REQ-032 Sweep all 65536 in_x against a reference model of REQ-013..REQ-015 -> zero mismatches.
